// File: rtl/fetch_pc_unit_pkg.sv
// Shared control-path definitions for the fetch stage: PC-select encodings,
// the fetch-stage nop and field widths of the execute-stage redirect inputs.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_JT  = 2'b10,
    PCSEL_JR  = 2'b11
  } pcsel_e;

  localparam logic [31:0] NOP_INSN = 32'h0;
  localparam int          IMM_W    = 17;
  localparam int          TGT_W    = 27;

  function automatic logic signed [31:0] sext_imm(input logic [IMM_W-1:0] imm);
    logic signed [IMM_W-1:0] s;
    s = $signed(imm);
    return 32'(s);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_select.sv
// Combinational redirect resolution for the instruction in execute: decides
// whether fetch is redirected and produces the pc to load on the next edge.
module next_pc_select
  import fetch_pc_unit_pkg::*;
(
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [1:0]       pc_mux,
  input  logic             bne,
  input  logic             blt,
  input  logic             alu_ne,
  input  logic             alu_lt,
  input  logic [31:0]      ex_pc_plus1,
  input  logic [IMM_W-1:0] ex_imm,
  input  logic [TGT_W-1:0] ex_target,
  input  logic [31:0]      rd_val,
  input  logic [31:0]      pc,
  output logic             redirect,
  output logic [31:0]      next_pc
);

  logic        w_branch;
  logic        w_jump;
  logic        w_taken;
  logic [31:0] w_target;

  always_comb begin
    w_branch = ex_valid & ((pc_mux == PCSEL_BR) | blt);
    w_jump   = ex_valid & pc_mux[1];
    w_taken  = (bne & alu_ne) | (blt & alu_lt);
    redirect = ~stall & (w_jump | (w_branch & w_taken));

    // A jump overrides a branch recognised in the same cycle.
    if (w_jump) begin
      if (pc_mux == PCSEL_JT) w_target = {{(32-TGT_W){1'b0}}, ex_target};
      else                    w_target = rd_val;
    end else begin
      w_target = ex_pc_plus1 + sext_imm(ex_imm);
    end

    if (stall)         next_pc = pc;
    else if (redirect) next_pc = w_target;
    else               next_pc = pc + 32'd1;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, fetch/decode latch and redirect counter. Redirects flush the
// wrong-path word in F/D, costing exactly one bubble.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [1:0]        pc_mux,
  input  logic              bne,
  input  logic              blt,
  input  logic              alu_ne,
  input  logic              alu_lt,
  input  logic [31:0]       ex_pc_plus1,
  input  logic [IMM_W-1:0]  ex_imm,
  input  logic [TGT_W-1:0]  ex_target,
  input  logic [31:0]       rd_val,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       fd_insn,
  output logic [31:0]       fd_pc_plus1,
  output logic              fd_valid,
  output logic              redirect,
  output logic [CNT_W-1:0]  redirect_count
);

  logic [31:0]      r_pc;
  logic [31:0]      r_fd_insn;
  logic [31:0]      r_fd_pc_plus1;
  logic             r_fd_valid;
  logic [CNT_W-1:0] r_redirect_count;
  logic             w_redirect;
  logic [31:0]      w_next_pc;

  next_pc_select u_next_pc_select (
    .stall       (stall),
    .ex_valid    (ex_valid),
    .pc_mux      (pc_mux),
    .bne         (bne),
    .blt         (blt),
    .alu_ne      (alu_ne),
    .alu_lt      (alu_lt),
    .ex_pc_plus1 (ex_pc_plus1),
    .ex_imm      (ex_imm),
    .ex_target   (ex_target),
    .rd_val      (rd_val),
    .pc          (r_pc),
    .redirect    (w_redirect),
    .next_pc     (w_next_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc             <= '0;
      r_fd_insn        <= NOP_INSN;
      r_fd_pc_plus1    <= '0;
      r_fd_valid       <= 1'b0;
      r_redirect_count <= '0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (w_redirect) begin
        r_fd_insn     <= NOP_INSN;
        r_fd_pc_plus1 <= '0;
        r_fd_valid    <= 1'b0;
        if (r_redirect_count != {CNT_W{1'b1}})
          r_redirect_count <= r_redirect_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_fd_insn     <= imem_data;
        r_fd_pc_plus1 <= r_pc + 32'd1;
        r_fd_valid    <= 1'b1;
      end
    end
  end

  assign imem_addr      = r_pc[ADDR_W-1:0];
  assign fd_insn        = r_fd_insn;
  assign fd_pc_plus1    = r_fd_pc_plus1;
  assign fd_valid       = r_fd_valid;
  assign redirect       = w_redirect & ~reset;
  assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a cycle-level architectural model
// predicts each cycle's outputs; a monitor compares them on the falling edge.
module tb_fetch_pc_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  pc_mux;
  logic        bne;
  logic        blt;
  logic        alu_ne;
  logic        alu_lt;
  logic [31:0] ex_pc_plus1;
  logic [16:0] ex_imm;
  logic [26:0] ex_target;
  logic [31:0] rd_val;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] fd_insn;
  logic [31:0] fd_pc_plus1;
  logic        fd_valid;
  logic        redirect;
  logic [15:0] redirect_count;

  fetch_pc_unit #(.ADDR_W(12), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .pc_mux         (pc_mux),
    .bne            (bne),
    .blt            (blt),
    .alu_ne         (alu_ne),
    .alu_lt         (alu_lt),
    .ex_pc_plus1    (ex_pc_plus1),
    .ex_imm         (ex_imm),
    .ex_target      (ex_target),
    .rd_val         (rd_val),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fd_insn        (fd_insn),
    .fd_pc_plus1    (fd_pc_plus1),
    .fd_valid       (fd_valid),
    .redirect       (redirect),
    .redirect_count (redirect_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: unique, never zero, derived from the address.
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {4'hC, a, 4'h3, ~a};
  endfunction

  assign imem_data = mem_word(imem_addr);

  typedef struct {
    logic        redir;
    logic [11:0] addr;
    logic [31:0] insn;
    logic [31:0] pc1;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_insn;
  logic [31:0] m_pc1;
  logic        m_valid;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("redirect",       32'(redirect),       32'(e.redir));
        chk("imem_addr",      32'(imem_addr),      32'(e.addr));
        chk("fd_insn",        fd_insn,             e.insn);
        chk("fd_pc_plus1",    fd_pc_plus1,         e.pc1);
        chk("fd_valid",       32'(fd_valid),       32'(e.valid));
        chk("redirect_count", 32'(redirect_count), 32'(e.cnt));
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic ev, input logic [1:0] mux,
                      input logic b_ne, input logic b_lt, input logic a_ne, input logic a_lt,
                      input logic [31:0] pcp1, input logic [16:0] imm,
                      input logic [26:0] tgt, input logic [31:0] rv);
    logic        jump, branch, tkn, redir;
    logic [31:0] target;
    logic [31:0] simm;
    exp_t        e;
    @(posedge clock);
    #1;
    reset = rst; stall = st; ex_valid = ev; pc_mux = mux;
    bne = b_ne; blt = b_lt; alu_ne = a_ne; alu_lt = a_lt;
    ex_pc_plus1 = pcp1; ex_imm = imm; ex_target = tgt; rd_val = rv;
    if (rst) begin
      m_pc = 0; m_insn = 0; m_pc1 = 0; m_valid = 0; m_cnt = 0;
    end
    jump   = ev && mux[1];
    branch = ev && (mux == 2'b01 || b_lt);
    tkn    = (b_ne && a_ne) || (b_lt && a_lt);
    redir  = !rst && !st && (jump || (branch && tkn));
    simm   = {{15{imm[16]}}, imm};
    if (jump) target = (mux == 2'b10) ? {5'd0, tgt} : rv;
    else      target = pcp1 + simm;
    e.redir = redir;
    e.addr  = m_pc[11:0];
    e.insn  = m_insn;
    e.pc1   = m_pc1;
    e.valid = m_valid;
    e.cnt   = 16'(m_cnt);
    exp_q.push_back(e);
    if (!rst && !st) begin
      if (redir) begin
        m_pc = target; m_insn = 0; m_pc1 = 0; m_valid = 0;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_insn  = mem_word(m_pc[11:0]);
        m_pc1   = m_pc + 1;
        m_pc    = m_pc + 1;
        m_valid = 1;
      end
    end
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jt(input logic st, input logic [26:0] tgt);
    step(0, st, 1, 2'b10, 0, 0, 0, 0, 0, 0, tgt, 0);
  endtask

  task automatic jr(input logic [31:0] rv);
    step(0, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, rv);
  endtask

  initial begin : driver
    reset = 1; stall = 0; ex_valid = 0; pc_mux = 0; bne = 0; blt = 0;
    alu_ne = 0; alu_lt = 0; ex_pc_plus1 = 0; ex_imm = 0; ex_target = 0; rd_val = 0;
    m_pc = 0; m_insn = 0; m_pc1 = 0; m_valid = 0; m_cnt = 0;
    repeat (2) @(posedge clock);
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    seq(5);
    // taken bne: 10 + (-4) = 6
    step(0, 0, 1, 2'b01, 1, 0, 1, 0, 32'd10, 17'h1FFFC, 0, 0);
    seq(3);
    // untaken blt at pc 20
    jt(0, 27'd20);
    step(0, 0, 1, 2'b00, 0, 1, 1, 0, 32'd21, 17'h00010, 0, 0);
    seq(2);
    // branch selected with no qualifier set: not taken
    step(0, 0, 1, 2'b01, 0, 0, 1, 1, 32'd5, 17'h00005, 0, 0);
    seq(1);
    // jump beats a taken branch; then jr
    step(0, 0, 1, 2'b10, 1, 1, 1, 1, 32'd100, 17'h00003, 27'h0000100, 0);
    seq(2);
    jr(32'h0000_0ABC);
    seq(2);
    // stall over a pending jump, then release
    for (int i = 0; i < 3; i++) jt(1, 27'h0000300);
    jt(0, 27'h0000300);
    seq(2);
    // reset mid-operation with a jump presented, and reset during a stall
    jt(0, 27'h0000777);
    step(1, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 27'h0000555, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    seq(3);
    step(0, 1, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
    step(1, 1, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
    seq(2);
    // pc wrap at 2^32
    jr(32'hFFFF_FFFE);
    seq(4);
    // randomized mix
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] mux;
      mux = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
           mux, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, 17'($urandom), 27'($urandom), $urandom);
    end
    // counter saturation: 2^16 + 3 redirects from a cleared counter
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65539; i++) jt(0, 27'($urandom));
    seq(3);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
